// File: rtl/echo_driver.sv
// rtl/echo_driver.sv - SPART echo driver: programs the baud divisor, then echoes received bytes through a buffer.
// Define ECHO_DRIVER_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register is used.
module echo_driver #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  br_cfg,
    output logic                        iocs,
    output logic                        iorw,
    output logic [1:0]                  ioaddr,
    input  logic                        rda,
    input  logic                        tbr,
    inout  wire  [7:0]                  databus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        init_done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [2:0] LOAD_LO = 3'd0;
    localparam logic [2:0] LOAD_HI = 3'd1;
    localparam logic [2:0] IDLE    = 3'd2;
    localparam logic [2:0] READ    = 3'd3;
    localparam logic [2:0] WRITE   = 3'd4;

    function automatic logic [15:0] div_for(input logic [1:0] sel);
        case (sel)
            2'b00:   return 16'(CLK_FREQ_HZ / (16 * 4800) - 1);
            2'b01:   return 16'(CLK_FREQ_HZ / (16 * 9600) - 1);
            2'b10:   return 16'(CLK_FREQ_HZ / (16 * 19200) - 1);
            default: return 16'(CLK_FREQ_HZ / (16 * 38400) - 1);
        endcase
    endfunction

    logic [2:0]  state;
    logic [2:0]  nxt;
    logic        load_pend;
    logic [1:0]  cfg_q;
    logic        drive;
    logic [7:0]  dout;
    logic [15:0] div_new;
    logic [15:0] div_cur;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  head;
    logic        push;
    logic        pop;

    assign div_new = div_for(br_cfg);
    assign div_cur = div_for(cfg_q);
    assign push    = (state == READ);
    assign pop     = (state == WRITE);
    assign databus = drive ? dout : 8'bz;

`ifdef ECHO_DRIVER_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= databus;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
            count  <= count + CW'(1);
        end else if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
            count  <= count - CW'(1);
        end
    end

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
`else
    logic [7:0] hold;
    logic       hold_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld <= 1'b0;
        end else if (push) begin
            hold     <= databus;
            hold_vld <= 1'b1;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end

    assign fifo_full  = hold_vld;
    assign fifo_empty = !hold_vld;
    assign head       = hold;
    assign fifo_count = {{(CW-1){1'b0}}, hold_vld};
`endif

    // A baud change outranks everything; a full buffer drains before accepting more.
    always_comb begin
        nxt = IDLE;
        if (load_pend) begin
            nxt = LOAD_LO;
        end else begin
            case (state)
                LOAD_LO: nxt = LOAD_HI;
                IDLE: begin
                    if (br_cfg != cfg_q)           nxt = LOAD_LO;
                    else if (fifo_full && tbr)     nxt = WRITE;
                    else if (rda && !fifo_full)    nxt = READ;
                    else if (tbr && !fifo_empty)   nxt = WRITE;
                    else                           nxt = IDLE;
                end
                default: nxt = IDLE;
            endcase
        end
    end

    // Bus outputs are decoded from the next state so they appear with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD_LO;
            load_pend <= 1'b1;
            cfg_q     <= br_cfg;
            iocs      <= 1'b0;
            iorw      <= 1'b1;
            ioaddr    <= 2'b00;
            drive     <= 1'b0;
            dout      <= 8'h00;
            init_done <= 1'b0;
        end else begin
            load_pend <= 1'b0;
            state     <= nxt;
            iocs      <= (nxt != IDLE);
            iorw      <= (nxt == READ) || (nxt == IDLE);
            init_done <= (nxt != LOAD_LO) && (nxt != LOAD_HI);
            ioaddr    <= 2'b00;
            drive     <= 1'b0;
            case (nxt)
                LOAD_LO: begin
                    cfg_q  <= br_cfg;
                    ioaddr <= 2'b10;
                    drive  <= 1'b1;
                    dout   <= div_new[7:0];
                end
                LOAD_HI: begin
                    ioaddr <= 2'b11;
                    drive  <= 1'b1;
                    dout   <= div_cur[15:8];
                end
                WRITE: begin
                    drive <= 1'b1;
                    dout  <= head;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_driver.sv
// tb/tb_echo_driver.sv - self-checking bench for echo_driver with a queue-based bus model.
module tb_echo_driver;

`ifdef ECHO_DRIVER_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif
    localparam int N3 = (DEPTH < 3) ? DEPTH : 3;
    localparam int M5 = (DEPTH < 5) ? DEPTH : 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;
    wire  [7:0] databus;
    logic [3:0] fifo_count;
    logic       init_done;
    logic [7:0] rx_byte;
    logic [7:0] zz = 8'bz;

    int n_checks = 0;
    int n_pass   = 0;

    echo_driver #(.CLK_FREQ_HZ(50000000), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .iocs(iocs), .iorw(iorw),
        .ioaddr(ioaddr), .rda(rda), .tbr(tbr), .databus(databus),
        .fifo_count(fifo_count), .init_done(init_done)
    );

    assign databus = (iocs === 1'b1 && iorw === 1'b1) ? rx_byte : 8'bz;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [15:0] div_m(input logic [1:0] sel);
        int baud;
        baud = 4800 << sel;
        return 16'(50000000 / (16 * baud) - 1);
    endfunction

    // Bus-action model: 0 none, 1 divisor low, 2 divisor high, 3 read, 4 write.
    int         act;
    bit         pend;
    bit         init;
    bit         mvalid = 1'b0;
    logic [1:0] prog;
    logic [7:0] q[$];

    always @(posedge clk) begin
        int nact;
        if (rst) begin
            act = 0; pend = 1'b1; prog = br_cfg; q.delete(); init = 1'b0;
        end else begin
            if (act == 3) q.push_back(rx_byte);
            if (act == 4) void'(q.pop_front());
            if (pend)                              nact = 1;
            else if (act == 1)                     nact = 2;
            else if (act != 0)                     nact = 0;
            else if (br_cfg != prog)               nact = 1;
            else if (q.size() == DEPTH && tbr)     nact = 4;
            else if (rda && q.size() < DEPTH)      nact = 3;
            else if (tbr && q.size() != 0)         nact = 4;
            else                                   nact = 0;
            if (nact == 1) prog = br_cfg;
            pend = 1'b0;
            act  = nact;
            init = (act != 1) && (act != 2);
        end
        mvalid = 1'b1;
    end

    always @(negedge clk) begin
        logic [15:0] d;
        if (mvalid) begin
            d = div_m(prog);
            check("m_iocs", 16'(iocs), 16'(act != 0));
            check("m_init_done", 16'(init_done), 16'(init));
            check("m_fifo_count", 16'(fifo_count), 16'(q.size()));
            if (act != 0) begin
                check("m_iorw", 16'(iorw), 16'(act == 3));
                check("m_ioaddr", 16'(ioaddr), (act == 1) ? 16'd2 : (act == 2) ? 16'd3 : 16'd0);
            end
            case (act)
                0: check("m_bus_z", 16'(databus), 16'(zz));
                1: check("m_bus_div_lo", 16'(databus), 16'(d[7:0]));
                2: check("m_bus_div_hi", 16'(databus), 16'(d[15:8]));
                4: check("m_bus_echo", 16'(databus), 16'(q[0]));
                default: ;
            endcase
        end
    end

    // mode: 0 write access, 1 read access, 2 any access
    task automatic wait_acc(input int mode, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (iocs === 1'b1 && (mode == 2 || iorw === mode[0])) found = 1'b1;
        end
        check(name, 16'(found), 16'd1);
    endtask

    task automatic do_read(input logic [7:0] b);
        rx_byte = b;
        rda = 1'b1;
        wait_acc(1, "wait_read");
        rda = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int reads;
        int accs;
        rst = 1'b1; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; rx_byte = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_iocs", 16'(iocs), 16'd0);
        check("rst_iorw", 16'(iorw), 16'd1);
        check("rst_ioaddr", 16'(ioaddr), 16'd0);
        check("rst_count", 16'(fifo_count), 16'd0);
        check("rst_init", 16'(init_done), 16'd0);
        check("rst_bus_z", 16'(databus), 16'(zz));

        rst = 1'b0;
        wait_acc(0, "wait_load_lo");
        check("init_lo_addr", 16'(ioaddr), 16'd2);
        check("init_lo_data", 16'(databus), 16'h0044);
        check("init_lo_done", 16'(init_done), 16'd0);
        @(negedge clk);
        check("init_hi_addr", 16'(ioaddr), 16'd3);
        check("init_hi_data", 16'(databus), 16'h0001);
        @(negedge clk);
        check("init_done_up", 16'(init_done), 16'd1);
        check("init_idle", 16'(iocs), 16'd0);

        for (int i = 0; i < N3; i++) do_read(8'(8'h41 + i));
        check("count_after_reads", 16'(fifo_count), 16'(N3));
        tbr = 1'b1;
        for (int i = 0; i < N3; i++) begin
            wait_acc(0, "wait_echo");
            check("echo_byte", 16'(databus), 16'(8'h41 + i));
        end
        tbr = 1'b0;
        @(negedge clk);
        check("count_drained", 16'(fifo_count), 16'd0);

        reads = 0; accs = 0; rx_byte = 8'h60; rda = 1'b1;
        for (int c = 0; c < 4 * DEPTH + 10; c++) begin
            @(negedge clk);
            if (iocs === 1'b1) accs++;
            if (iocs === 1'b1 && iorw === 1'b1) reads++;
            else rx_byte = rx_byte + 8'd1;
        end
        check("fill_reads", 16'(reads), 16'(DEPTH));
        check("fill_no_extra_iocs", 16'(accs), 16'(DEPTH));
        check("fill_count", 16'(fifo_count), 16'(DEPTH));
        tbr = 1'b1;
        wait_acc(2, "wait_after_full");
        check("full_first_is_write", 16'(iorw), 16'd0);
        for (int c = 0; c < 6 * DEPTH + 8; c++) begin
            @(negedge clk);
            if (!(iocs === 1'b1 && iorw === 1'b1)) rx_byte = rx_byte + 8'd3;
        end
        rda = 1'b0;
        begin
            bit empty = 1'b0;
            for (int c = 0; c < 200 && !empty; c++) begin
                @(negedge clk);
                if (fifo_count == 0) empty = 1'b1;
            end
            check("drain_done", 16'(empty), 16'd1);
        end
        tbr = 1'b0;
        repeat (2) @(negedge clk);

        rx_byte = 8'h71; rda = 1'b1;
        wait_acc(1, "wait_read_brchg");
        br_cfg = 2'b11; rda = 1'b0;
        @(negedge clk);
        check("brchg_idle", 16'(iocs), 16'd0);
        @(negedge clk);
        check("brchg_lo_addr", 16'(ioaddr), 16'd2);
        check("brchg_lo_data", 16'(databus), 16'h0050);
        check("brchg_init_low", 16'(init_done), 16'd0);
        @(negedge clk);
        check("brchg_hi_addr", 16'(ioaddr), 16'd3);
        check("brchg_hi_data", 16'(databus), 16'h0000);
        @(negedge clk);
        check("brchg_init_up", 16'(init_done), 16'd1);
        check("brchg_retained", 16'(fifo_count), 16'd1);
        tbr = 1'b1;
        wait_acc(0, "wait_echo_after_reload");
        check("echo_after_reload", 16'(databus), 16'h0071);
        tbr = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < M5; i++) do_read(8'(8'h90 + i));
        tbr = 1'b1;
        wait_acc(0, "wait_write_rst");
        check("count_in_write", 16'(fifo_count), 16'(M5));
        rst = 1'b1; tbr = 1'b0;
        @(negedge clk);
        check("abort_iocs", 16'(iocs), 16'd0);
        check("abort_bus_z", 16'(databus), 16'(zz));
        check("abort_count", 16'(fifo_count), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reprog_addr", 16'(ioaddr), 16'd2);
        check("reprog_lo", 16'(databus), 16'h0050);
        repeat (3) @(negedge clk);

        br_cfg = 2'b10;
        wait_acc(0, "wait_br10");
        check("br10_lo", 16'(databus), 16'h00A1);
        @(negedge clk);
        check("br10_hi", 16'(databus), 16'h0000);
        repeat (2) @(negedge clk);
        br_cfg = 2'b00;
        wait_acc(0, "wait_br00");
        check("br00_lo", 16'(databus), 16'h008A);
        @(negedge clk);
        check("br00_hi", 16'(databus), 16'h0002);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
